qar_spi_slave: RTL and testbench

QAR_SPI_SLAVE -- requirements
Module: qar_spi_slave

---
 rtl/qar_spi_slave_pkg.sv | 28 ++
 rtl/qar_spi_defs.vh | 12 +
 rtl/qar_sync2.sv | 25 ++
 rtl/qar_spi_slave.sv | 194 +++++++++++++++++++
 tb/tb_qar_spi_slave.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qar_spi_slave_pkg.sv
// Types, constants and a small shift helper shared by the SPI slave files.
package qar_spi_slave_pkg;

  `include "qar_spi_defs.vh"

  // Frame state: IDLE while chip select is high, ACTIVE while a frame runs.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // Width of the bit counter that walks through one frame.
  localparam int BIT_CNT_W = $clog2(QAR_SPI_FRAME_W);

  // Cycles after reset before the chip-select synchronizer output is trusted.
  // The synchronizer starts at its reset value, so until it has refilled
  // with real samples an apparent cs_n edge could be an artefact of reset.
  localparam int SETTLE_CYCLES = 3;

  // Append one bit below a (FRAME_W-1)-bit history, producing a full frame.
  function automatic logic [QAR_SPI_FRAME_W-1:0] shift_in(
    input logic [QAR_SPI_FRAME_W-2:0] prior,
    input logic                       new_bit
  );
    return {prior, new_bit};
  endfunction

endpackage

// File: rtl/qar_spi_defs.vh
// Shared SPI constants used by both the SPI slave and the core SPI master.
// Both sides must agree on the frame width and the idle/fill pattern.
`ifndef QAR_SPI_DEFS_VH
`define QAR_SPI_DEFS_VH

// Number of bits in one SPI frame (one byte, MSB first).
localparam int QAR_SPI_FRAME_W = 8;

// Byte shifted out when the transmit side has nothing queued.
localparam logic [QAR_SPI_FRAME_W-1:0] QAR_SPI_FILL_BYTE = 8'hFF;

`endif

// File: rtl/qar_sync2.sv
// Two-flop synchronizer for one asynchronous input bit, with a
// parameterised reset value so idle-high signals come out of reset idle.
module qar_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qar_spi_slave.sv
// SPI slave (modes 0 and 3, MSB first, 8-bit frames) with a one-entry
// transmit holding buffer and a single-byte receive register.
// All SPI pins are oversampled by clk; each raw edge takes effect exactly
// three clk cycles later (two synchronizer flops plus one edge register).
module qar_spi_slave
  import qar_spi_slave_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  localparam int W = QAR_SPI_FRAME_W;

  // Synchronized pins and the one-cycle-delayed copies used for edge detect.
  logic sck_sync;
  logic cs_n_sync;
  logic mosi_sync;
  logic sck_prev;
  logic cs_n_prev;

  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;

  // Post-reset guard so a cs_n that is already low does not start a frame.
  logic [1:0] settle_cnt;
  logic       cs_armed;

  // Frame state and datapath.
  spi_state_t           state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 seen_rise;
  logic [W-1:0]         tx_sr;
  logic [W-2:0]         rx_sr;
  logic [W-1:0]         rx_shift;

  // One-entry transmit holding buffer.
  logic         buf_full;
  logic [W-1:0] buf_data;
  logic         buf_write;

  // Load and shift strobes for the transmit shift register.
  logic frame_start;
  logic byte_load;
  logic load_evt;
  logic tx_shift_evt;

  qar_sync2 #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .d   (spi_sck),
    .q   (sck_sync)
  );

  qar_sync2 #(.RESET_VAL(1'b1)) u_sync_cs_n (
    .clk (clk),
    .rst (rst),
    .d   (spi_cs_n),
    .q   (cs_n_sync)
  );

  qar_sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d   (spi_mosi),
    .q   (mosi_sync)
  );

  // Remember last cycle's synchronized sck and cs_n for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_prev  <= 1'b0;
      cs_n_prev <= 1'b1;
    end else begin
      sck_prev  <= sck_sync;
      cs_n_prev <= cs_n_sync;
    end
  end

  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;
  assign cs_fall  = ~cs_n_sync & cs_n_prev;
  assign cs_rise  = cs_n_sync & ~cs_n_prev;

  // Arm frame starts only once the synchronizer has refilled after reset
  // and chip select has been seen high, so only a fresh falling edge counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      cs_armed   <= 1'b0;
    end else if (settle_cnt != 2'(SETTLE_CYCLES)) begin
      settle_cnt <= settle_cnt + 2'd1;
    end else if (cs_n_sync && cs_n_prev) begin
      cs_armed <= 1'b1;
    end
  end

  // A frame starts on an armed cs_n fall; a new byte is loaded on the first
  // sck fall after a completed byte. Falls before any rise (the mode-3
  // leading edge) neither load nor shift.
  assign frame_start  = (state == IDLE) && cs_fall && cs_armed;
  assign byte_load    = (state == ACTIVE) && !cs_rise && sck_fall && seen_rise &&
                        (bit_cnt == '0);
  assign load_evt     = frame_start || byte_load;
  assign tx_shift_evt = (state == ACTIVE) && !cs_rise && sck_fall && seen_rise &&
                        (bit_cnt != '0);

  // A write is accepted only into an empty buffer, so a load in the same
  // cycle necessarily sees the old (empty) contents.
  assign buf_write = tx_valid && !buf_full;
  assign tx_ready  = !buf_full;

  // Full received frame: seven held bits plus the bit arriving now.
  assign rx_shift = shift_in(rx_sr, mosi_sync);

  // Frame FSM, shift registers, holding buffer and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      seen_rise   <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      buf_full    <= 1'b0;
      buf_data    <= '0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (load_evt) begin
        if (buf_full) begin
          tx_sr <= buf_data;
        end else begin
          tx_sr       <= QAR_SPI_FILL_BYTE;
          tx_underrun <= 1'b1;
        end
      end else if (tx_shift_evt) begin
        tx_sr <= shift_in(tx_sr[W-2:0], 1'b0);
      end

      if (buf_write) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end else if (load_evt) begin
        buf_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= ACTIVE;
            bit_cnt   <= '0;
            seen_rise <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (sck_rise) begin
            rx_sr     <= rx_shift[W-2:0];
            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            seen_rise <= 1'b1;
            if (bit_cnt == BIT_CNT_W'(W - 1)) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state == ACTIVE);
  assign spi_miso_oe = busy;
  assign spi_miso    = busy & tx_sr[W-1];

endmodule

// File: tb/tb_qar_spi_slave.sv
// Self-checking bench for qar_spi_slave using a behavioural SPI master
// (sck half period of 8 clk) and a byte-level reference model.
module tb_qar_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Master-side frame description and capture.
  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];
  logic [7:0] m_wd [4];
  bit         m_wr [4];
  int         cs_cyc;

  // Monitor captures.
  logic [7:0] rx_q [$];
  int         under_cyc [$];

  qar_spi_slave dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every rx_valid cycle and every tx_underrun cycle.
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_underrun) under_cyc.push_back(cyc);
  end

  task automatic half_period();
    repeat (8) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic clear_monitors();
    rx_q.delete();
    under_cyc.delete();
  endtask

  // Behavioural master: sends nbits of m_tx MSB first, captures MISO on each
  // rise into m_rx, and writes m_wd[b+1] mid-gap after byte b when m_wr[b+1].
  // In mode 0 the final sck fall comes after cs_n deasserts.
  task automatic run_frame(input int nbytes, input int nbits, input bit m3);
    spi_sck = m3;
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b0;
    cs_cyc   = cyc;
    half_period();
    for (int idx = 0; idx < nbits; idx++) begin
      int b = idx / 8;
      int k = 7 - (idx % 8);
      if (m3) spi_sck = 1'b0;
      spi_mosi = m_tx[b][k];
      half_period();
      spi_sck = 1'b1;
      m_rx[b][k] = spi_miso;
      if (k == 0 && b + 1 < nbytes && m_wr[b+1]) begin
        repeat (5) @(negedge clk);
        write_byte(m_wd[b+1]);
        repeat (2) @(negedge clk);
      end else begin
        half_period();
      end
      if (!m3 && idx != nbits - 1) spi_sck = 1'b0;
    end
    spi_cs_n = 1'b1;
    half_period();
    spi_sck = m3;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (tx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if ({spi_miso, spi_miso_oe} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_miso: got %b expected 00", {spi_miso, spi_miso_oe}); end
    tests_run++;
    if ({rx_valid, tx_underrun} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_pulses: got %b expected 00", {rx_valid, tx_underrun}); end
    tests_run++;
    if (rx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_monitors();
    m_wr[1] = 1'b0;
    write_byte(8'hA5);
    m_tx[0] = 8'h3C;
    run_frame(1, 8, 1'b0);
    tests_run++;
    if (m_rx[0] !== 8'hA5) begin tests_failed++; $display("[TB] FAIL basic_miso: got %h expected a5", m_rx[0]); end
    tests_run++;
    if (rx_data !== 8'h3C) begin tests_failed++; $display("[TB] FAIL basic_rx_data: got %h expected 3c", rx_data); end
    tests_run++;
    if (rx_q.size() !== 1) begin tests_failed++; $display("[TB] FAIL basic_rx_valid_count: got %0d expected 1", rx_q.size()); end
    tests_run++;
    if (under_cyc.size() !== 0) begin tests_failed++; $display("[TB] FAIL basic_underrun: got %0d expected 0", under_cyc.size()); end
    tests_run++;
    if (tx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_tx_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_two_byte();
    clear_monitors();
    m_tx[0] = 8'($urandom); m_tx[1] = 8'($urandom);
    m_wr[1] = 1'b1; m_wd[1] = 8'h22;
    write_byte(8'h11);
    run_frame(2, 16, 1'b0);
    tests_run++;
    if ({m_rx[0], m_rx[1]} !== 16'h1122) begin tests_failed++; $display("[TB] FAIL two_byte_miso: got %h%h expected 1122", m_rx[0], m_rx[1]); end
    tests_run++;
    if (rx_q.size() !== 2) begin
      tests_failed++; $display("[TB] FAIL two_byte_rx_count: got %0d expected 2", rx_q.size());
    end else if ({rx_q[0], rx_q[1]} !== {m_tx[0], m_tx[1]}) begin
      tests_failed++; $display("[TB] FAIL two_byte_rx_data: got %h%h expected %h%h", rx_q[0], rx_q[1], m_tx[0], m_tx[1]);
    end
    tests_run++;
    if (under_cyc.size() !== 0) begin tests_failed++; $display("[TB] FAIL two_byte_underrun: got %0d expected 0", under_cyc.size()); end
  endtask

  task automatic test_underrun();
    clear_monitors();
    m_wr[1] = 1'b0;
    m_tx[0] = 8'($urandom);
    run_frame(1, 8, 1'b0);
    tests_run++;
    if (m_rx[0] !== 8'hFF) begin tests_failed++; $display("[TB] FAIL underrun_miso: got %h expected ff", m_rx[0]); end
    tests_run++;
    if (under_cyc.size() !== 1) begin
      tests_failed++; $display("[TB] FAIL underrun_count: got %0d expected 1", under_cyc.size());
    end else if (under_cyc[0] - cs_cyc !== 3) begin
      tests_failed++; $display("[TB] FAIL underrun_latency: got %0d expected 3", under_cyc[0] - cs_cyc);
    end
    tests_run++;
    if (rx_data !== m_tx[0]) begin tests_failed++; $display("[TB] FAIL underrun_rx_data: got %h expected %h", rx_data, m_tx[0]); end
  endtask

  task automatic test_mode3();
    clear_monitors();
    m_wr[1] = 1'b0;
    write_byte(8'h5A);
    m_tx[0] = 8'hC3;
    run_frame(1, 8, 1'b1);
    tests_run++;
    if (m_rx[0] !== 8'h5A) begin tests_failed++; $display("[TB] FAIL mode3_miso: got %h expected 5a", m_rx[0]); end
    tests_run++;
    if (rx_data !== 8'hC3) begin tests_failed++; $display("[TB] FAIL mode3_rx_data: got %h expected c3", rx_data); end
    tests_run++;
    if (rx_q.size() !== 1 || under_cyc.size() !== 0) begin tests_failed++; $display("[TB] FAIL mode3_pulses: got rx %0d und %0d expected rx 1 und 0", rx_q.size(), under_cyc.size()); end
  endtask

  task automatic test_abort();
    logic [7:0] pre;
    clear_monitors();
    m_wr[1] = 1'b0;
    m_tx[0] = 8'($urandom);
    run_frame(1, 4, 1'b0);
    tests_run++;
    if (rx_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL abort_rx_valid: got %0d expected 0", rx_q.size()); end
    tests_run++;
    if ({busy, tx_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL abort_state: got busy,tx_ready=%b expected 01", {busy, tx_ready}); end
    pre     = 8'($urandom);
    m_tx[0] = 8'($urandom);
    write_byte(pre);
    run_frame(1, 8, 1'b0);
    tests_run++;
    if (m_rx[0] !== pre) begin tests_failed++; $display("[TB] FAIL abort_next_miso: got %h expected %h", m_rx[0], pre); end
    tests_run++;
    if (rx_q.size() !== 1 || rx_data !== m_tx[0]) begin tests_failed++; $display("[TB] FAIL abort_next_rx: got %0d x %h expected 1 x %h", rx_q.size(), rx_data, m_tx[0]); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] pre;
    clear_monitors();
    write_byte(8'($urandom));
    spi_sck  = 1'b0;
    spi_cs_n = 1'b0;
    half_period();
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      half_period();
      spi_sck = 1'b1;
      half_period();
      if (i < 3) spi_sck = 1'b0;
    end
    write_byte(8'($urandom));
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, spi_miso, spi_miso_oe, rx_valid, tx_underrun} !== 5'b0) begin tests_failed++; $display("[TB] FAIL midreset_outputs: got %b expected 00000", {busy, spi_miso, spi_miso_oe, rx_valid, tx_underrun}); end
    tests_run++;
    if (tx_ready !== 1'b1 || rx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL midreset_regs: got tx_ready %b rx_data %h expected 1 00", tx_ready, rx_data); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_no_restart: got busy %b expected 0", busy); end
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    repeat (10) @(negedge clk);
    pre     = 8'($urandom);
    m_tx[0] = 8'($urandom);
    m_wr[1] = 1'b0;
    write_byte(pre);
    run_frame(1, 8, 1'b0);
    tests_run++;
    if (m_rx[0] !== pre || rx_data !== m_tx[0]) begin tests_failed++; $display("[TB] FAIL midreset_recovery: got %h/%h expected %h/%h", m_rx[0], rx_data, pre, m_tx[0]); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      bit         m3;
      int         n;
      int         exp_under;
      logic [7:0] exp_byte;
      m3 = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        m_tx[i] = 8'($urandom);
        m_wd[i] = 8'($urandom);
        m_wr[i] = 1'($urandom_range(0, 1));
      end
      clear_monitors();
      if (m_wr[0]) write_byte(m_wd[0]);
      run_frame(n, n * 8, m3);
      exp_under = 0;
      for (int i = 0; i < n; i++) begin
        exp_byte = m_wr[i] ? m_wd[i] : 8'hFF;
        if (!m_wr[i]) exp_under++;
        tests_run++;
        if (m_rx[i] !== exp_byte) begin tests_failed++; $display("[TB] FAIL random_miso f%0d b%0d: got %h expected %h", f, i, m_rx[i], exp_byte); end
      end
      tests_run++;
      if (under_cyc.size() !== exp_under) begin tests_failed++; $display("[TB] FAIL random_underrun f%0d: got %0d expected %0d", f, under_cyc.size(), exp_under); end
      tests_run++;
      if (rx_q.size() !== n) begin
        tests_failed++; $display("[TB] FAIL random_rx_count f%0d: got %0d expected %0d", f, rx_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          if (rx_q[i] !== m_tx[i]) begin tests_failed++; $display("[TB] FAIL random_rx f%0d b%0d: got %h expected %h", f, i, rx_q[i], m_tx[i]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_byte();
    test_underrun();
    test_mode3();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
